serial_to_parallel_rx: RTL
==========================

Name: serial_to_parallel_rx

Overview:
Receive-side counterpart of the universal shift register. It accumulates a serial bit stream into WIDTH-bit words, MSB-first or LSB-first. Each completed word is presented on a parallel output through a one-entry valid/ready holding buffer. It sits at the far end of a serial link driven by a shift register in shift-left or shift-right mode, and reports dropped words through a sticky overrun flag.

Parameters:
WIDTH, 4, bits per received word (WIDTH >= 2)
CNT_W, $clog2(WIDTH+1), width of the bit counter and bit_count port

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clock edge)
serial_in  input  1  incoming serial data bit
serial_valid  input  1  serial_in is sampled on this edge when high
lsb_first  input  1  0 = MSB-first word, 1 = LSB-first word
clear  input  1  synchronous flush of the partial word and overrun flag
DATAOUT  output  WIDTH  received parallel word (holding buffer)
out_valid  output  1  DATAOUT holds an unconsumed word
out_ready  input  1  consumer accepts DATAOUT when high with out_valid
bit_count  output  CNT_W  bits accumulated in the current partial word (0..WIDTH-1)
overrun  output  1  sticky: a completed word was dropped

Behaviour:
- Reset (reset==0 at a rising edge): DATAOUT=0, out_valid=0, overrun=0, bit_count=0, shift register=0, latched direction=0. Reset has priority over every other input and aborts any partial word.
- Serial side has no backpressure. Every edge with serial_valid=1 (and clear=0) accepts one bit.
- Direction latch:
  - lsb_first is sampled when the first bit of a word is accepted (bit_count==0) and held for the rest of that word.
  - Changes to lsb_first mid-word are ignored until the next word.
- Shift rules:
  - MSB-first: sr <= {sr[WIDTH-2:0], serial_in}. The first bit ends in DATAOUT[WIDTH-1].
  - LSB-first: sr <= {serial_in, sr[WIDTH-1:1]}. The first bit ends in DATAOUT[0].
- Counter:
  - bit_count increments per accepted bit.
  - On the WIDTH-th bit it wraps to 0, and the completed word (including that bit) is offered to the buffer in the same edge.
- Latency: DATAOUT and out_valid update on the edge that samples the final bit. They are visible in the following cycle.
- Idle cycles (serial_valid=0) between bits are allowed; the partial word and bit_count are held.
- Buffer FSM, two states:
  - EMPTY: out_valid=0. A completed word loads DATAOUT → FULL.
  - FULL: out_valid=1, DATAOUT held stable.
    - out_ready=1 with no word completing → EMPTY. DATAOUT keeps its last value; it is not zeroed.
    - out_ready=1 and a word completing on the same edge → new word loaded, stay FULL, no overrun.
    - out_ready=0 and a word completing → new word discarded, DATAOUT unchanged, overrun <= 1, stay FULL.
- clear (reset inactive):
  - Zeroes the shift register and bit_count and clears overrun.
  - A bit presented on the same edge is discarded.
  - The output buffer (DATAOUT, out_valid) and the out_ready handshake are unaffected.
- overrun stays 1 until reset or clear.

Decomposition:
- Shared package rx_pkg:
  - default WIDTH constant
  - buffer state typedef (BUF_EMPTY, BUF_FULL)
  - direction encoding constants (DIR_MSB_FIRST=0, DIR_LSB_FIRST=1)
- One sub-module, sipo_shift_core. It holds the shift register, the direction latch and the bit counter, and emits a one-cycle word_done strobe with the word.
- The top level holds the buffer FSM and the overrun logic.

Test Plan:
1. WIDTH=4, lsb_first=0, out_ready=1, bits 1,0,1,1 on consecutive cycles -> DATAOUT=4'b1011, out_valid high exactly one cycle after the 4th sampling edge; bit_count sequence 1,2,3,0.
2. lsb_first=1, same bits 1,0,1,1 -> DATAOUT=4'b1101. Toggling lsb_first after bit 2 of the next word has no effect on that word.
3. out_ready=0; send 0011 then 0111 -> DATAOUT stays 4'b0011, out_valid=1, overrun=1 after the 8th bit. Pulse clear -> overrun=0, DATAOUT still 4'b0011.
4. Buffer FULL with 4'b0011; raise out_ready on the same edge as the final bit of 1010 (MSB-first) -> DATAOUT=4'b1010, out_valid stays 1, overrun stays 0.
5. Drive reset=0 for one edge after 2 bits of a word, with a word pending in the buffer -> DATAOUT=0, out_valid=0, bit_count=0. The next bits 0,1,1,0 give DATAOUT=4'b0110.
6. Bits 1,1 with serial_valid gaps of 3 idle cycles, then clear together with serial_valid=1 -> bit_count=0, that bit discarded. The following bits 1,0,0,1 give DATAOUT=4'b1001.

Source files
------------

// File: rtl/serial_to_parallel_rx_pkg.sv
// Shared definitions for the serial-to-parallel receiver.
//   RX_WIDTH      : default number of bits per received word
//   buf_state_t   : state of the one-entry output holding buffer
//   DIR_*         : encoding of the latched word direction (lsb_first input)
package rx_pkg;

  localparam int RX_WIDTH = 4;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_to_parallel_rx_if.sv
// Bus interface of the serial-to-parallel receiver.
//   serial_in / serial_valid : incoming bit stream, no backpressure
//   lsb_first                : word direction, sampled at the first bit of a word
//   clear                    : flush partial word and overrun flag
//   DATAOUT / out_valid / out_ready : valid/ready word output
//   bit_count                : bits held in the current partial word
//   overrun                  : sticky dropped-word flag
// master = link/consumer side (testbench), slave = receiver.
interface serial_to_parallel_rx_if
  import rx_pkg::*;
#(
  parameter int WIDTH = RX_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             serial_in;
  logic             serial_valid;
  logic             lsb_first;
  logic             clear;
  logic [WIDTH-1:0] DATAOUT;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] bit_count;
  logic             overrun;

  modport master (
    output serial_in, serial_valid, lsb_first, clear, out_ready,
    input  DATAOUT, out_valid, bit_count, overrun
  );

  modport slave (
    input  serial_in, serial_valid, lsb_first, clear, out_ready,
    output DATAOUT, out_valid, bit_count, overrun
  );

endinterface

// File: rtl/serial_to_parallel_rx_sipo_shift_core.sv
// Shift core of the receiver: shift register, direction latch and bit counter.
//   clock, reset (sync, active-low), serial_in, serial_valid, lsb_first, clear
//   word      : the completed word, valid only while word_done is high
//   word_done : high during the cycle whose rising edge accepts the last bit
//   bit_count : bits accumulated in the current partial word
module sipo_shift_core
  import rx_pkg::*;
#(
  parameter int WIDTH = RX_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             lsb_first,
  input  logic             clear,
  output logic [WIDTH-1:0] word,
  output logic             word_done,
  output logic [CNT_W-1:0] bit_count
);

  logic [WIDTH-1:0] sr;
  logic             dir_q;
  logic             dir_eff;
  logic [WIDTH-1:0] sr_next;
  logic             accept;
  logic             last_bit;

  // The first bit of a word takes its direction straight from lsb_first;
  // later bits use the value latched with that first bit.
  assign dir_eff  = (bit_count == '0) ? lsb_first : dir_q;
  assign sr_next  = (dir_eff == DIR_LSB_FIRST) ? {serial_in, sr[WIDTH-1:1]}
                                               : {sr[WIDTH-2:0], serial_in};
  assign accept   = serial_valid && !clear;
  assign last_bit = (bit_count == CNT_W'(WIDTH - 1));

  // The completed word is presented combinationally so the buffer can load it
  // on the same edge that samples the final bit.
  assign word      = sr_next;
  assign word_done = accept && last_bit;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sr        <= '0;
      bit_count <= '0;
      dir_q     <= DIR_MSB_FIRST;
    end else if (clear) begin
      sr        <= '0;
      bit_count <= '0;
    end else if (serial_valid) begin
      sr    <= sr_next;
      dir_q <= dir_eff;
      if (last_bit) bit_count <= '0;
      else          bit_count <= bit_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words from a serial stream
// (MSB- or LSB-first) and offers them through a one-entry valid/ready buffer.
//   clock : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : serial_to_parallel_rx_if.slave (serial input, word output, status)
// A word completing while the buffer is full and not being drained is dropped
// and sets the sticky overrun flag.
module serial_to_parallel_rx
  import rx_pkg::*;
#(
  parameter int WIDTH = RX_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  serial_to_parallel_rx_if.slave  bus
);

  logic [WIDTH-1:0] word;
  logic             word_done;
  buf_state_t       state, state_next;
  logic             load;
  logic             drop;

  sipo_shift_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clock        (clock),
    .reset        (reset),
    .serial_in    (bus.serial_in),
    .serial_valid (bus.serial_valid),
    .lsb_first    (bus.lsb_first),
    .clear        (bus.clear),
    .word         (word),
    .word_done    (word_done),
    .bit_count    (bus.bit_count)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= BUF_EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    drop       = 1'b0;
    case (state)
      BUF_EMPTY: begin
        if (word_done) begin
          load       = 1'b1;
          state_next = BUF_FULL;
        end
      end
      BUF_FULL: begin
        // A word arriving as the held one is consumed replaces it directly.
        if (word_done) begin
          if (bus.out_ready) load = 1'b1;
          else               drop = 1'b1;
        end else if (bus.out_ready) begin
          state_next = BUF_EMPTY;
        end
      end
      default: state_next = BUF_EMPTY;
    endcase
  end

  // DATAOUT keeps its last word after it is consumed; only reset zeroes it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      bus.DATAOUT <= '0;
      bus.overrun <= 1'b0;
    end else begin
      if (load) bus.DATAOUT <= word;
      if (bus.clear)  bus.overrun <= 1'b0;
      else if (drop)  bus.overrun <= 1'b1;
    end
  end

  assign bus.out_valid = (state == BUF_FULL);

endmodule
